// File: rtl/dpsram_pkg.sv
// Shared definitions for initiators of the byte-writable dual-port SRAM:
// burst FSM state encoding, default widths and the response FIFO beat format.
package dpsram_pkg;

   localparam int DPSRAM_ADDR_WIDTH = 10;
   localparam int DPSRAM_LEN_WIDTH  = 4;
   localparam int DPSRAM_FIFO_DEPTH = 4;
   localparam int DPSRAM_DATA_WIDTH = 32;
   localparam int DPSRAM_STRB_WIDTH = DPSRAM_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } burst_state_t;

   // One read-response beat as stored in the response FIFO.
   typedef struct packed {
      logic                         last;
      logic [DPSRAM_DATA_WIDTH-1:0] data;
   } rsp_beat_t;

endpackage

// File: rtl/dpsram_rsp_fifo.sv
// Read-response FIFO for dpsram_burst_master. Holds {last, data} beats,
// show-ahead read port, exposes its occupancy for credit tracking.
// Push while full is legal only together with a pop (the slot is recycled).
module dpsram_rsp_fifo
   import dpsram_pkg::*;
#(
   parameter int DEPTH = DPSRAM_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  rsp_beat_t              push_data,
   input  logic                   pop,
   output rsp_beat_t              pop_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rsp_beat_t        store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage write; validity lives in count, so the array itself needs no reset.
   // NOTE: storage arrays are left unreset; the consumer gates the read port with
   // the occupancy, which keeps the array out of the reset tree.
   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign pop_data = store[rd_ptr];

endmodule

// File: rtl/dpsram_burst_master.sv
// Burst initiator for one port of the byte-writable dual-port SRAM.
// Converts command / write-data / read-data streams into mem_* accesses.
// The SRAM cannot stall, so reads are only issued while the response FIFO
// has a free slot counting the beat already in flight.
// Optional: define DPSRAM_BURST_WRAP_EN to wrap bursts inside the aligned
// 2^LEN_WIDTH-word block (critical-word-first cache fills).
module dpsram_burst_master
   import dpsram_pkg::*;
#(
   parameter int ADDR_WIDTH = DPSRAM_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DPSRAM_LEN_WIDTH,
   parameter int FIFO_DEPTH = DPSRAM_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [31:0]           wr_data,
   input  logic [3:0]            wr_strb,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [31:0]           rd_data,
   output logic                  rd_last,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W = CNT_W + 1;

   burst_state_t          state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [LEN_WIDTH-1:0]  beats_left;
   logic                  inflight;
   logic                  inflight_last;
   logic [CNT_W-1:0]      fifo_count;
   logic [OCC_W-1:0]      occupancy;
   logic                  rd_pop;
   logic                  rd_issue;
   logic                  wr_beat;
   logic                  last_beat;
   rsp_beat_t             push_beat;
   rsp_beat_t             head_beat;

   assign cmd_ready = (state == ST_IDLE);
   assign wr_ready  = (state == ST_WRITE);
   assign last_beat = (beats_left == '0);

   // Credit: FIFO entries plus the beat in flight, less the entry popped this
   // cycle, so a pop on a full FIFO re-opens issue in the same cycle.
   assign rd_pop    = rd_valid & rd_ready;
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(rd_pop);
   assign rd_issue  = (state == ST_READ) && (occupancy < OCC_W'(FIFO_DEPTH));
   assign wr_beat   = (state == ST_WRITE) && wr_valid;

`ifdef DPSRAM_BURST_WRAP_EN
   // Only the in-block offset advances; the aligned block base is held.
   logic [LEN_WIDTH-1:0] low_next;
   assign low_next  = cur_addr[LEN_WIDTH-1:0] + LEN_WIDTH'(1);
   assign next_addr = {cur_addr[ADDR_WIDTH-1:LEN_WIDTH], low_next};
`else
   // Linear increment, wrapping naturally at the top of the address space.
   assign next_addr = cur_addr + ADDR_WIDTH'(1);
`endif

   // SRAM port drive: one access per write beat or read issue, idle-zero otherwise.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      mem_en   = 1'b0;
      mem_we   = '0;
      mem_addr = '0;
      mem_din  = '0;
      if (wr_beat) begin
         mem_en   = 1'b1;
         mem_we   = wr_strb;
         mem_addr = cur_addr;
         mem_din  = wr_data;
      end else if (rd_issue) begin
         mem_en   = 1'b1;
         mem_addr = cur_addr;
      end
   end

   // Burst FSM with address/beat counters and the one-deep in-flight read tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         cur_addr      <= '0;
         beats_left    <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge values of the others.
         inflight      <= rd_issue;
         inflight_last <= rd_issue & last_beat;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cur_addr   <= cmd_addr;
                  beats_left <= cmd_len;
                  state      <= cmd_write ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE, ST_READ: begin
               if (wr_beat || rd_issue) begin
                  if (last_beat) begin
                     state <= ST_IDLE;
                  end else begin
                     beats_left <= beats_left - LEN_WIDTH'(1);
                     cur_addr   <= next_addr;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // SRAM data lands one cycle after issue and is captured with its last tag.
   assign push_beat = '{last: inflight_last, data: mem_dout};

   dpsram_rsp_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .push_data(push_beat),
      .pop      (rd_pop),
      .pop_data (head_beat),
      .count    (fifo_count)
   );

   // Read port is gated by occupancy so stale storage never reaches the client.
   assign rd_valid = (fifo_count != '0);
   assign rd_data  = rd_valid ? head_beat.data : '0;
   assign rd_last  = rd_valid & head_beat.last;

endmodule

// File: tb/tb_dpsram_burst_master.sv
// Self-checking bench for dpsram_burst_master with a behavioural
// read-before-write byte-writable SRAM model on the mem_* port.
module tb_dpsram_burst_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        rd_valid, rd_ready, rd_last;
   logic [31:0] rd_data;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       wv;
      logic [3:0] we;
      logic [9:0] addr;
   } mem_ev_t;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } wvec_t;

   logic [31:0] sram [1024];
   mem_ev_t     mem_q [$];
   logic [32:0] rd_q  [$];

   dpsram_burst_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // SRAM model: 1-cycle read latency, read-before-write, byte enables.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout <= sram[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
   end

   // Monitors: SRAM accesses and accepted read beats.
   always @(posedge clk) begin
      if (mem_en) mem_q.push_back('{wv: wr_valid, we: mem_we, addr: mem_addr});
      if (rd_valid && rd_ready) rd_q.push_back({rd_last, rd_data});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic send_cmd(input logic w, input logic [9:0] a, input logic [3:0] len);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [9:0] a, input int nbeats, input logic [31:0] base,
                              input logic [3:0] strb, input bit gaps);
      send_cmd(1'b1, a, 4'(nbeats - 1));
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         if (gaps && i > 0) begin wr_valid = 1'b0; @(negedge clk); end
         wr_valid = 1'b1; wr_data = base + 32'(i); wr_strb = strb;
         while (!wr_ready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_reads(input int cnt);
      int n = 0;
      while (rd_q.size() < cnt && n < 300) begin @(negedge clk); n++; end
      check("rd_beat_count", 32'(rd_q.size()), 32'(cnt));
   endtask

   wvec_t       vecs [6];
   logic [9:0]  wrap_exp [4];
   int          lat;

   initial begin
      // Byte-strobe vectors, applied in order to the same few addresses.
      vecs[0] = '{addr: 10'h020, data: 32'h11223344, strb: 4'hF, exp: 32'h11223344};
      vecs[1] = '{addr: 10'h020, data: 32'hFFFFFFFF, strb: 4'h5, exp: 32'h11FF33FF};
      vecs[2] = '{addr: 10'h021, data: 32'hDEADBEEF, strb: 4'hF, exp: 32'hDEADBEEF};
      vecs[3] = '{addr: 10'h021, data: 32'h00000000, strb: 4'h0, exp: 32'hDEADBEEF};
      vecs[4] = '{addr: 10'h021, data: 32'h12345678, strb: 4'hA, exp: 32'h12AD56EF};
      vecs[5] = '{addr: 10'h3FF, data: 32'hCAFEF00D, strb: 4'hC, exp: 32'hCAFE0000};
`ifdef DPSRAM_BURST_WRAP_EN
      wrap_exp = '{10'h3FE, 10'h3FF, 10'h3F0, 10'h3F1};
`else
      wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
`endif
      for (int i = 0; i < 1024; i++) sram[i] = '0;

      rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_wr_ready",  32'(wr_ready),  32'd0);
      check("rst_rd_valid",  32'(rd_valid),  32'd0);
      check("rst_rd_last",   32'(rd_last),   32'd0);
      check("rst_rd_data",   rd_data,        32'd0);
      check("rst_mem_en",    32'(mem_en),    32'd0);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_din",   mem_din,        32'd0);
      rst = 1'b0;
      @(negedge clk);

      // wr_valid while idle is ignored.
      wr_valid = 1'b1; wr_data = 32'h55; wr_strb = 4'hF;
      #1;
      check("idle_wr_mem_en", 32'(mem_en),   32'd0);
      check("idle_wr_ready",  32'(wr_ready), 32'd0);
      @(negedge clk);
      wr_valid = 1'b0;
      check("idle_wr_cmd_ready", 32'(cmd_ready), 32'd1);

      // 4-beat write then readback with first-data latency.
      write_burst(10'h010, 4, 32'hA0, 4'hF, 1'b0);
      rd_q.delete();
      send_cmd(1'b0, 10'h010, 4'd3);
      lat = 1;
      while (!rd_valid && lat < 20) begin @(negedge clk); lat++; end
      check("rd_first_latency", 32'(lat), 32'd3);
      wait_reads(4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("burstA_data%0d", i), rd_q[i][31:0], 32'hA0 + 32'(i));
         check($sformatf("burstA_last%0d", i), 32'(rd_q[i][32]), 32'(i == 3));
      end

      // Table: single-beat strobed writes, each read back.
      for (int v = 0; v < 6; v++) begin
         write_burst(vecs[v].addr, 1, vecs[v].data, vecs[v].strb, 1'b0);
         rd_q.delete();
         send_cmd(1'b0, vecs[v].addr, 4'd0);
         wait_reads(1);
         check($sformatf("vec%0d_data", v), rd_q[0][31:0], vecs[v].exp);
         check($sformatf("vec%0d_last", v), 32'(rd_q[0][32]), 32'd1);
      end

      // Write data with gaps: accesses only on valid cycles, exactly four.
      mem_q.delete();
      write_burst(10'h200, 4, 32'hC0, 4'hF, 1'b1);
      check("gap_write_count", 32'(mem_q.size()), 32'd4);
      for (int i = 0; i < mem_q.size(); i++) begin
         check($sformatf("gap_wv%0d", i),   32'(mem_q[i].wv),   32'd1);
         check($sformatf("gap_addr%0d", i), 32'(mem_q[i].addr), 32'h200 + 32'(i));
      end

      // Backpressure: 16-beat read, rd_ready low for 10 cycles.
      write_burst(10'h100, 16, 32'hB000, 4'hF, 1'b0);
      rd_ready = 1'b0;
      mem_q.delete(); rd_q.delete();
      send_cmd(1'b0, 10'h100, 4'd15);
      repeat (9) @(negedge clk);
      check("bp_issues_stalled", 32'(mem_q.size()), 32'd4);
      check("bp_rd_valid_held",  32'(rd_valid),     32'd1);
      check("bp_rd_data_held",   rd_data,           32'hB000);
      rd_ready = 1'b1;
      wait_reads(16);
      check("bp_total_issues", 32'(mem_q.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("bp_data%0d", i), rd_q[i][31:0], 32'hB000 + 32'(i));
         check($sformatf("bp_last%0d", i), 32'(rd_q[i][32]), 32'(i == 15));
      end

      // Address wrap at the top of the space.
      mem_q.delete(); rd_q.delete();
      send_cmd(1'b0, 10'h3FE, 4'd3);
      wait_reads(4);
      for (int i = 0; i < 4; i++)
         check($sformatf("wrap_addr%0d", i), 32'(mem_q[i].addr), 32'(wrap_exp[i]));

      // Reset during beat 2 of an 8-beat read.
      send_cmd(1'b0, 10'h100, 4'd7);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_mem_en",    32'(mem_en),    32'd0);
      check("midrst_mem_addr",  32'(mem_addr),  32'd0);
      check("midrst_rd_valid",  32'(rd_valid),  32'd0);
      check("midrst_rd_data",   rd_data,        32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("postrst_rd_valid",  32'(rd_valid),  32'd0);
      check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
      rd_q.delete();
      send_cmd(1'b0, 10'h010, 4'd3);
      wait_reads(4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("postrst_data%0d", i), rd_q[i][31:0], 32'hA0 + 32'(i));
         check($sformatf("postrst_last%0d", i), 32'(rd_q[i][32]), 32'(i == 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
